// File: rtl/alu_reg32.sv
// Registered 32-bit MIPS-style ALU: eight operations selected by alucontrol,
// result and zero flag captured on the rising edge (one cycle of latency).
module alu_reg32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  typedef enum logic [2:0] {
    OpAnd    = 3'b000,
    OpOr     = 3'b001,
    OpAdd    = 3'b010,
    OpXor    = 3'b011,
    OpAndNot = 3'b100,
    OpOrNot  = 3'b101,
    OpSub    = 3'b110,
    OpSlt    = 3'b111
  } aluop_e;

  aluop_e           op;
  logic             invert_b;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] sum;
  logic             slt;
  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  assign op = aluop_e'(alucontrol);

  // Bit 2 of the code selects ~b for the whole upper half; it also supplies the
  // carry-in, so one adder serves ADD, SUB (a + ~b + 1) and the SLT difference.
  assign invert_b = alucontrol[2];
  assign b_sel    = invert_b ? ~b : b;
  assign sum      = a + b_sel + {{(WIDTH-1){1'b0}}, invert_b};

  // Differing signs mean the subtraction may overflow; sign(a) decides then.
  assign slt = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : sum[WIDTH-1];

  always_comb begin
    result_d = '0;
    unique case (op)
      OpAnd:    result_d = a & b;
      OpOr:     result_d = a | b;
      OpAdd:    result_d = sum;
      OpXor:    result_d = a ^ b;
      OpAndNot: result_d = a & b_sel;
      OpOrNot:  result_d = a | b_sel;
      OpSub:    result_d = sum;
      OpSlt:    result_d = {{(WIDTH-1){1'b0}}, slt};
      default:  result_d = '0;
    endcase
  end

  // Zero is taken from the same next-state value so it never lags the result.
  assign zero_d = (result_d == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_reg32.sv
// Self-checking bench for alu_reg32: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_alu_reg32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alucontrol;
  logic [31:0] result;
  logic        zero;

  int vectors     = 0;
  int miscompares = 0;

  alu_reg32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .alucontrol (alucontrol),
    .result     (result),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x + y;
      3'd3:    return x ^ y;
      3'd4:    return x & ~y;
      3'd5:    return x | ~y;
      3'd6:    return x - y;
      default: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Drive one operation, check after the edge, then scramble inputs and check hold.
  task automatic apply(input string tag, input logic r, input logic [31:0] ai,
                       input logic [31:0] bi, input logic [2:0] op);
    logic [31:0] exp;
    reset = r; a = ai; b = bi; alucontrol = op;
    @(posedge clk);
    #1;
    exp = r ? 32'd0 : model(ai, bi, op);
    check({tag, ".result"}, result, exp);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
    a = $urandom; b = $urandom; alucontrol = 3'($urandom_range(0, 7));
    #3;
    check({tag, ".hold"}, result, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    apply("rst0", 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b010);
    apply("rst1", 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b010);
    apply("wrap", 1'b0, 32'hFFFF_FFFF, 32'd1, 3'b010);

    apply("slt_eq", 1'b0, 32'h0B, 32'h0B, 3'b111);
    apply("slt_gt", 1'b0, 32'h0B, 32'h0A, 3'b111);
    apply("slt_lt", 1'b0, 32'h0A, 32'h0B, 3'b111);

    apply("sub_neg", 1'b0, 32'h0A, 32'h0B, 3'b110);
    apply("sub_eq", 1'b0, 32'h1234_5678, 32'h1234_5678, 3'b110);

    apply("slt_ovf0", 1'b0, 32'h8000_0000, 32'h0000_0001, 3'b111);
    apply("slt_ovf1", 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b111);

    apply("and", 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000);
    apply("or", 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001);
    apply("xor", 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011);
    apply("andn", 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100);
    apply("orn", 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b101);

    apply("b2b_add", 1'b0, 32'd5, 32'd3, 3'b010);
    apply("b2b_sub", 1'b0, 32'd5, 32'd3, 3'b110);
    apply("mid_rst", 1'b1, 32'd5, 32'd3, 3'b010);
    apply("post_rst", 1'b0, 32'd5, 32'd3, 3'b010);

    for (int i = 0; i < 400; i++) begin
      apply("rand", ($urandom_range(0, 31) == 0), pick(), pick(),
            3'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
